// File: rtl/dmem_wbuf.sv
// Write-through buffer between L1 D-cache and L2: coalescing FIFO of whole lines,
// drained in order to L2, with L1 fills forwarded from queued lines when they hit.
module dmem_wbuf #(
   parameter int LINE_W = 256,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [63:0]       u_addr,
   input  logic              u_rd,
   output logic [LINE_W-1:0] u_data_out,
   output logic              u_dv,
   input  logic              u_wr,
   input  logic [LINE_W-1:0] u_data_in,
   output logic              u_full,
   output logic              ovf,
   output logic              empty,
   output logic [63:0]       l2_addr,
   output logic              l2_rd,
   output logic              l2_wr,
   output logic [LINE_W-1:0] l2_data_out,
   input  logic [LINE_W-1:0] l2_data_in,
   input  logic              l2_dv
);
   localparam int OFFS = $clog2(LINE_W/8);
   localparam int AW   = 64 - OFFS;
   localparam int PW   = $clog2(DEPTH);
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, RECOVER} state_t;
   typedef struct packed {
      logic [AW-1:0]     line;
      logic [LINE_W-1:0] data;
   } ent_t;

   ent_t          ent [DEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   state_t        state;

   logic          wr_hit, rd_hit, push, pop, wr_fwd;
   logic [PW-1:0] wr_idx, rd_idx;
   logic          offs_unused;

   assign offs_unused = ^u_addr[OFFS-1:0];

   // Scan oldest to newest so the newest matching entry wins.
   always_comb begin : scan
      logic [PW-1:0] idx;
      idx    = '0;
      wr_hit = 1'b0;
      rd_hit = 1'b0;
      wr_idx = '0;
      rd_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (k < int'(count) && ent[idx].line == u_addr[63:OFFS]) begin
            rd_hit = 1'b1;
            rd_idx = idx;
            if (!(state == DRAIN && k == 0)) begin
               wr_hit = 1'b1;
               wr_idx = idx;
            end
         end
      end
   end

   assign push   = u_wr && !wr_hit && (count != CNT_FULL);
   assign pop    = (state == DRAIN) && l2_dv;
   // A write coalescing into the head on the very cycle its drain launches
   // must reach L2, so it is forwarded straight into the write data register.
   assign wr_fwd = u_wr && wr_hit && (wr_idx == head);
   assign u_full = (count == CNT_FULL);
   assign empty  = (count == '0);

   always_ff @(posedge clk) begin
      if (u_wr && wr_hit)
         ent[wr_idx].data <= u_data_in;
      else if (push)
         ent[tail] <= '{line: u_addr[63:OFFS], data: u_data_in};
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state       <= IDLE;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         ovf         <= 1'b0;
         u_dv        <= 1'b0;
         u_data_out  <= '0;
         l2_rd       <= 1'b0;
         l2_wr       <= 1'b0;
         l2_addr     <= '0;
         l2_data_out <= '0;
      end else begin
         if (u_wr && !wr_hit && count == CNT_FULL)
            ovf <= 1'b1;
         if (push)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;

         case (state)
            IDLE: begin
               if (u_rd && rd_hit) begin
                  u_data_out <= ent[rd_idx].data;
                  u_dv       <= 1'b1;
                  state      <= RECOVER;
               end else if (u_rd) begin
                  l2_rd   <= 1'b1;
                  l2_addr <= {u_addr[63:OFFS], {OFFS{1'b0}}};
                  state   <= READ;
               end else if (count != '0) begin
                  l2_wr       <= 1'b1;
                  l2_addr     <= {ent[head].line, {OFFS{1'b0}}};
                  l2_data_out <= wr_fwd ? u_data_in : ent[head].data;
                  state       <= DRAIN;
               end
            end
            READ: begin
               if (l2_dv) begin
                  u_data_out <= l2_data_in;
                  u_dv       <= 1'b1;
                  l2_rd      <= 1'b0;
                  state      <= RECOVER;
               end
            end
            DRAIN: begin
               if (l2_dv) begin
                  l2_wr <= 1'b0;
                  state <= IDLE;
               end
            end
            RECOVER: begin
               u_dv  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
